// File: rtl/c1_pkg.sv
// Shared definitions for the C1 logic cell: default lane count and a
// reference evaluation of the cell equation for a single lane.
package c1_pkg;

  localparam int C1_DEFAULT_WIDTH = 1;

  // One-lane C1 equation: A mux, B mux, final mux selected by s0|s1.
  function automatic logic c1_eval(input logic a0, input logic a1, input logic sa,
                                   input logic b0, input logic b1, input logic sb,
                                   input logic s0, input logic s1);
    logic a;
    logic b;
    a = sa ? a1 : a0;
    b = sb ? b1 : b0;
    return (s0 | s1) ? b : a;
  endfunction

endpackage

// File: rtl/c1_logic_cell_if.sv
// Signal bundle for the C1 logic cell. There is no valid/ready handshake:
// the inputs are sampled continuously, F follows them combinationally and
// F_q is refreshed on every rising clock edge outside reset.
interface c1_logic_cell_if
  import c1_pkg::*;
#(
  parameter int WIDTH = C1_DEFAULT_WIDTH
);
  logic [WIDTH-1:0] A0;
  logic [WIDTH-1:0] A1;
  logic [WIDTH-1:0] SA;
  logic [WIDTH-1:0] B0;
  logic [WIDTH-1:0] B1;
  logic [WIDTH-1:0] SB;
  logic [WIDTH-1:0] S0;
  logic [WIDTH-1:0] S1;
  logic [WIDTH-1:0] F;
  logic [WIDTH-1:0] F_q;

  modport master (
    output A0, A1, SA, B0, B1, SB, S0, S1,
    input  F, F_q
  );

  modport slave (
    input  A0, A1, SA, B0, B1, SB, S0, S1,
    output F, F_q
  );
endinterface

// File: rtl/c1_mux2.sv
// Single-bit 2:1 multiplexer, the leaf element of the C1 cell.
module c1_mux2 (
  input  logic d0,
  input  logic d1,
  input  logic s,
  output logic y
);

  // Plain conditional so an X on the unselected input does not reach y.
  assign y = s ? d1 : d0;

endmodule

// File: rtl/c1_logic_cell.sv
// Bit-sliced Actel-style C1 logic cell: per lane, an A mux and a B mux feed
// a final mux selected by S0|S1. F is combinational; F_q is F registered.
module c1_logic_cell
  import c1_pkg::*;
#(
  parameter int WIDTH = C1_DEFAULT_WIDTH
) (
  input logic            clk,
  input logic            rst,
  c1_logic_cell_if.slave bus
);

  logic [WIDTH-1:0] f_w;

  // One independent three-mux slice per lane.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic a_w;
    logic b_w;
    logic sel_w;

    assign sel_w = bus.S0[i] | bus.S1[i];

    c1_mux2 u_mux_a (
      .d0 (bus.A0[i]),
      .d1 (bus.A1[i]),
      .s  (bus.SA[i]),
      .y  (a_w)
    );

    c1_mux2 u_mux_b (
      .d0 (bus.B0[i]),
      .d1 (bus.B1[i]),
      .s  (bus.SB[i]),
      .y  (b_w)
    );

    c1_mux2 u_mux_f (
      .d0 (a_w),
      .d1 (b_w),
      .s  (sel_w),
      .y  (f_w[i])
    );
  end

  assign bus.F = f_w;

  // Pipeline copy of F; reset clears it immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.F_q <= '0;
    end else begin
      bus.F_q <= f_w;
    end
  end

endmodule

// File: tb/tb_c1_logic_cell.sv
// Self-checking bench for c1_logic_cell (4 lanes): directed vectors with
// literal expectations plus a per-cycle comparison against a table model.
module tb_c1_logic_cell;
  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  c1_logic_cell_if #(.WIDTH(W)) bus ();

  c1_logic_cell #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit running = 1'b0;

  // ---------------- model ----------------
  // Data pairs are looked up by their select as an array index, and the
  // final choice is "b unless both select terms are zero".
  function automatic logic [W-1:0] model_f(
      input logic [W-1:0] a0, input logic [W-1:0] a1, input logic [W-1:0] sa,
      input logic [W-1:0] b0, input logic [W-1:0] b1, input logic [W-1:0] sb,
      input logic [W-1:0] s0, input logic [W-1:0] s1);
    logic [W-1:0] r;
    logic [1:0] ap;
    logic [1:0] bp;
    logic [1:0] fp;
    int nsel;
    for (int i = 0; i < W; i++) begin
      ap = {a1[i], a0[i]};
      bp = {b1[i], b0[i]};
      nsel = int'(s0[i]) + int'(s1[i]);
      fp = {bp[sb[i]], ap[sa[i]]};
      r[i] = fp[(nsel != 0) ? 1 : 0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] cur_model();
    return model_f(bus.A0, bus.A1, bus.SA, bus.B0, bus.B1, bus.SB, bus.S0, bus.S1);
  endfunction

  // Expected registered output: zero in reset, else last-edge model value.
  logic [W-1:0] exp_fq;
  always @(posedge clk or posedge rst) begin
    if (rst) exp_fq <= '0;
    else     exp_fq <= cur_model();
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (running) begin
      chk("F_model", bus.F, cur_model());
      chk("Fq_model", bus.F_q, exp_fq);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [W-1:0] a0, input logic [W-1:0] a1, input logic [W-1:0] sa,
                       input logic [W-1:0] b0, input logic [W-1:0] b1, input logic [W-1:0] sb,
                       input logic [W-1:0] s0, input logic [W-1:0] s1);
    @(negedge clk);
    #1;
    bus.A0 = a0; bus.A1 = a1; bus.SA = sa;
    bus.B0 = b0; bus.B1 = b1; bus.SB = sb;
    bus.S0 = s0; bus.S1 = s1;
    #1;
  endtask

  // Replicate one single-bit vector {a0,a1,sa,b0,b1,sb,s0,s1} on every lane.
  task automatic drive_bits(input logic [7:0] v);
    drive({W{v[7]}}, {W{v[6]}}, {W{v[5]}}, {W{v[4]}},
          {W{v[3]}}, {W{v[2]}}, {W{v[1]}}, {W{v[0]}});
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] sel_exp;
  logic [W-1:0] ta0, ta1, tsa, tb0, tb1, tsb, ts0, ts1;
  logic [7:0] c;

  initial begin
    bus.A0 = '0; bus.A1 = '0; bus.SA = '0; bus.B0 = '0;
    bus.B1 = '0; bus.SB = '0; bus.S0 = '0; bus.S1 = '0;
    #2;
    chk("reset_Fq", bus.F_q, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    running = 1'b1;

    // Vector 1: selects B1=0.
    drive_bits(8'b0_1_0_1_0_1_0_1);
    chk("vec1_F", bus.F, 4'b0000);
    after_edge();
    chk("vec1_Fq", bus.F_q, 4'b0000);

    // Vector 2: selects B0=1.
    drive_bits(8'b0_1_1_1_0_0_0_1);
    chk("vec2_F", bus.F, 4'b1111);
    after_edge();
    chk("vec2_Fq", bus.F_q, 4'b1111);

    // Final-select OR sweep: S1S0 = 00,01,10,11 -> 1,0,0,0.
    sel_exp = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      drive_bits({6'b1_0_0_0_0_0, k[0], k[1]});
      chk("sel_or_F", bus.F, {W{sel_exp[k]}});
    end

    // Async reset between edges: F_q clears at once, F is untouched.
    drive_bits(8'b0_1_1_1_0_0_0_1);
    after_edge();
    chk("pre_rst_Fq", bus.F_q, 4'b1111);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_Fq", bus.F_q, 4'b0000);
    chk("rst_F", bus.F, 4'b1111);
    after_edge();
    chk("rst_hold_Fq", bus.F_q, 4'b0000);
    @(negedge clk);
    #1;
    rst = 1'b0;
    after_edge();
    chk("post_rst_Fq", bus.F_q, 4'b1111);

    // Multi-lane: lanes 3,2 take b (B0[3]=1, B1[2]=0), lanes 1,0 take a
    // (A1[1]=1, A1[0]=0).
    drive(4'b0101, 4'b1010, 4'b0011, 4'b1111, 4'b0000, 4'b0101, 4'b1000, 4'b0100);
    chk("lanes_F", bus.F, 4'b1010);
    after_edge();
    chk("lanes_Fq", bus.F_q, 4'b1010);

    // Exhaustive: every 8-input combination, each lane on a different one.
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < W; i++) begin
        c = 8'((k + i * 37) & 255);
        ta0[i] = c[7]; ta1[i] = c[6]; tsa[i] = c[5]; tb0[i] = c[4];
        tb1[i] = c[3]; tsb[i] = c[2]; ts0[i] = c[1]; ts1[i] = c[0];
      end
      drive(ta0, ta1, tsa, tb0, tb1, tsb, ts0, ts1);
    end
    @(negedge clk);
    @(negedge clk);
    running = 1'b0;
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
